p405s_icu_sram_arb: RTL and testbench

Single-port access controller for the ICU 512-word x 128-bit byte-writable instruction SRAM. It arbitrates each cycle between the fetch read requester and the line-fill write requester, and registers the selected command onto the SRAM pins. It also returns read data with a fixed-latency valid strobe. It optionally runs a clear sweep of the whole array after reset and on request. It sits between the ICU fetch/fill control logic and the SRAM wrapper.

---
 rtl/p405s_icu_sram_pkg.sv | 17 +
 rtl/p405s_icu_sram_init_seq.sv | 29 ++
 rtl/p405s_icu_sram_arb.sv | 161 ++++++++++++++++
 tb/tb_p405s_icu_sram_arb.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p405s_icu_sram_pkg.sv
// Shared constants and types for the ICU instruction SRAM access controller.
package p405s_icu_sram_pkg;

  localparam int ICU_SRAM_ADDR_W    = 9;
  localparam int ICU_SRAM_DATA_W    = 128;
  localparam int ICU_SRAM_BYTES     = 16;
  localparam int ICU_SRAM_LAST_ADDR = 511;

  // Active-low byte write enables with every lane disabled (read or idle)
  localparam logic [ICU_SRAM_BYTES-1:0] ICU_SRAM_WEN_OFF = '1;

  typedef enum logic {
    RUN  = 1'b0,
    INIT = 1'b1
  } icu_sram_state_e;

endpackage

// File: rtl/p405s_icu_sram_init_seq.sv
// Clear-sweep address sequencer for the ICU SRAM.
// Only meaningful when P405S_ICU_SRAM_INIT_EN is defined; the module is
// elaborated only in that build so the default build carries no sweep logic.
`ifdef P405S_ICU_SRAM_INIT_EN
module p405s_icu_sram_init_seq
  import p405s_icu_sram_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       active,
  output logic [ICU_SRAM_ADDR_W-1:0] sweep_addr,
  output logic                       sweep_done
);

  // Step through the array while a sweep is active; park at zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_addr <= '0;
    end else if (active) begin
      sweep_addr <= sweep_addr + ICU_SRAM_ADDR_W'(1);
    end else begin
      sweep_addr <= '0;
    end
  end

  assign sweep_done = active && (sweep_addr == ICU_SRAM_ADDR_W'(ICU_SRAM_LAST_ADDR));

endmodule
`endif

// File: rtl/p405s_icu_sram_arb.sv
// ICU instruction SRAM access controller: arbitrates fetch reads against
// line-fill writes, registers the SRAM command, and strobes read data back.
// Optional clear sweep after reset / on inv_all_req: P405S_ICU_SRAM_INIT_EN.
module p405s_icu_sram_arb
  import p405s_icu_sram_pkg::*;
#(
  parameter int ADDR_W     = ICU_SRAM_ADDR_W,
  parameter int DATA_W     = ICU_SRAM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                      cclk,
  input  logic                      rst_n,
  input  logic                      fetch_req,
  input  logic [ADDR_W-1:0]         fetch_addr,
  output logic                      fetch_gnt,
  output logic                      fetch_rd_vld,
  output logic [DATA_W-1:0]         fetch_rd_data,
  input  logic                      fill_req,
  input  logic [ADDR_W-1:0]         fill_addr,
  input  logic [ICU_SRAM_BYTES-1:0] fill_be,
  input  logic [DATA_W-1:0]         fill_data,
  output logic                      fill_gnt,
  input  logic                      inv_all_req,
  output logic                      init_busy,
  output logic                      sram_cen,
  output logic [ICU_SRAM_BYTES-1:0] sram_wen,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_din,
  input  logic [DATA_W-1:0]         sram_dout
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic                       in_init;
  logic [ICU_SRAM_ADDR_W-1:0] sweep_addr;
  logic [CNT_W-1:0]           starve_cnt;
  logic                       starved;
  logic [1:0]                 rd_tag;

  logic                       cen_d;
  logic [ICU_SRAM_BYTES-1:0]  wen_d;
  logic [ADDR_W-1:0]          addr_d;
  logic [DATA_W-1:0]          din_d;

`ifdef P405S_ICU_SRAM_INIT_EN
  icu_sram_state_e state_q, state_d;
  logic            sweep_done;

  // State register; reset lands in the clear sweep
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Enter the sweep on request from RUN, leave once the last address is issued
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (inv_all_req) state_d = INIT;
      INIT:    if (sweep_done)  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign in_init = (state_q == INIT);

  p405s_icu_sram_init_seq u_init_seq (
    .clk        (cclk),
    .rst_n      (rst_n),
    .active     (in_init),
    .sweep_addr (sweep_addr),
    .sweep_done (sweep_done)
  );
`else
  logic unused_inv_all_req;

  assign unused_inv_all_req = inv_all_req;
  assign in_init            = 1'b0;
  assign sweep_addr         = '0;
`endif

  assign init_busy = in_init;
  assign starved   = (starve_cnt == CNT_W'(STARVE_MAX));

  // Fill normally wins; a fetch starved for STARVE_MAX cycles takes the port
  always_comb begin
    fetch_gnt = 1'b0;
    fill_gnt  = 1'b0;
    if (!in_init) begin
      if (fetch_req && (starved || !fill_req)) begin
        fetch_gnt = 1'b1;
      end else if (fill_req) begin
        fill_gnt = 1'b1;
      end
    end
  end

  // Count denied fetch cycles, saturating at the starvation threshold
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!fetch_req || fetch_gnt) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Select the command to present on the SRAM pins next cycle
  always_comb begin
    cen_d  = 1'b1;
    wen_d  = ICU_SRAM_WEN_OFF;
    addr_d = sram_addr;
    din_d  = sram_din;
    if (in_init) begin
      cen_d  = 1'b0;
      wen_d  = '0;
      addr_d = ADDR_W'(sweep_addr);
      din_d  = '0;
    end else if (fill_gnt) begin
      cen_d  = (fill_be == '0);
      wen_d  = ~fill_be;
      addr_d = fill_addr;
      din_d  = fill_data;
    end else if (fetch_gnt) begin
      cen_d  = 1'b0;
      addr_d = fetch_addr;
    end
  end

  // Register the SRAM command so the macro sees clean, glitch-free pins
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      sram_cen  <= 1'b1;
      sram_wen  <= ICU_SRAM_WEN_OFF;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      sram_cen  <= cen_d;
      sram_wen  <= wen_d;
      sram_addr <= addr_d;
      sram_din  <= din_d;
    end
  end

  // Two-stage read tag: command cycle, then data-return cycle
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag <= '0;
    end else begin
      rd_tag <= {rd_tag[0], fetch_gnt};
    end
  end

  assign fetch_rd_vld  = rd_tag[1];
  assign fetch_rd_data = sram_dout;

endmodule

// File: tb/tb_p405s_icu_sram_arb.sv
// Directed self-checking bench for p405s_icu_sram_arb with a behavioural
// byte-writable SRAM attached to the command pins.
`timescale 1ns/1ps
module tb_p405s_icu_sram_arb;
  import p405s_icu_sram_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 128;

`ifdef P405S_ICU_SRAM_INIT_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  logic              cclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_gnt;
  logic              fetch_rd_vld;
  logic [DATA_W-1:0] fetch_rd_data;
  logic              fill_req = 1'b0;
  logic [ADDR_W-1:0] fill_addr = '0;
  logic [15:0]       fill_be = '0;
  logic [DATA_W-1:0] fill_data = '0;
  logic              fill_gnt;
  logic              inv_all_req = 1'b0;
  logic              init_busy;
  logic              sram_cen;
  logic [15:0]       sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  int n_checks = 0;
  int n_pass   = 0;

  p405s_icu_sram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .cclk          (cclk),
    .rst_n         (rst_n),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_gnt     (fetch_gnt),
    .fetch_rd_vld  (fetch_rd_vld),
    .fetch_rd_data (fetch_rd_data),
    .fill_req      (fill_req),
    .fill_addr     (fill_addr),
    .fill_be       (fill_be),
    .fill_data     (fill_data),
    .fill_gnt      (fill_gnt),
    .inv_all_req   (inv_all_req),
    .init_busy     (init_busy),
    .sram_cen      (sram_cen),
    .sram_wen      (sram_wen),
    .sram_addr     (sram_addr),
    .sram_din      (sram_din),
    .sram_dout     (sram_dout)
  );

  always #5 cclk = ~cclk;

  function automatic logic [127:0] init_word(input int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  function automatic logic [127:0] bb_word(input int k);
    return {4{32'h1000_0000 + 32'(k) * 32'h0101_0101}};
  endfunction

  // Behavioural SRAM: preloaded on the first edge, byte writes, Q next cycle
  logic [127:0] mem [512];
  bit           primed = 1'b0;
  always @(posedge cclk) begin
    if (!primed) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      primed <= 1'b1;
    end else if (!sram_cen) begin
      for (int b = 0; b < 16; b++)
        if (!sram_wen[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      sram_dout <= mem[sram_addr];
    end
  end

  // Wait out a clear sweep, counting busy cycles, protocol errors and read strobes
  task automatic run_sweep(output int cycles, output int errs, output int vlds);
    int c;
    cycles = 0; errs = 0; vlds = 0; c = 0;
    while (init_busy === 1'b1 && c < 700) begin
      if (c > 0 && (sram_cen !== 1'b0 || sram_wen !== 16'h0000 || sram_din !== '0 ||
                    sram_addr !== 9'(c - 1))) errs++;
      if (fetch_gnt !== 1'b0 || fill_gnt !== 1'b0) errs++;
      if (fetch_rd_vld === 1'b1) vlds++;
      cycles++; c++;
      @(negedge cclk); #1;
    end
  endtask

  task automatic test_reset();
    int cyc, err, vld;
    rst_n = 1'b0;
    repeat (3) @(negedge cclk);
    #1;
    n_checks++; if (sram_cen !== 1'b1) $display("[TB] FAIL reset_cen got %b want 1", sram_cen); else n_pass++;
    n_checks++; if (sram_wen !== 16'hFFFF) $display("[TB] FAIL reset_wen got %h want ffff", sram_wen); else n_pass++;
    n_checks++; if (sram_addr !== 9'h000) $display("[TB] FAIL reset_addr got %h want 000", sram_addr); else n_pass++;
    n_checks++; if (sram_din !== '0) $display("[TB] FAIL reset_din got %h want 0", sram_din); else n_pass++;
    n_checks++; if (fetch_rd_vld !== 1'b0) $display("[TB] FAIL reset_vld got %b want 0", fetch_rd_vld); else n_pass++;
    n_checks++; if (init_busy !== INIT_EN) $display("[TB] FAIL reset_init_busy got %b want %b", init_busy, INIT_EN); else n_pass++;
    rst_n = 1'b1;
    #1;
`ifdef P405S_ICU_SRAM_INIT_EN
    run_sweep(cyc, err, vld);
    n_checks++; if (cyc != 512) $display("[TB] FAIL sweep_len got %0d want 512", cyc); else n_pass++;
    n_checks++; if (err != 0) $display("[TB] FAIL sweep_pins got %0d errors want 0", err); else n_pass++;
    n_checks++; if (sram_addr !== 9'h1FF || sram_wen !== 16'h0000) $display("[TB] FAIL sweep_last got addr %h wen %h want 1ff 0000", sram_addr, sram_wen); else n_pass++;
    n_checks++; if (fetch_gnt !== 1'b0 || fill_gnt !== 1'b0) $display("[TB] FAIL sweep_exit_gnt got %b%b want 00", fetch_gnt, fill_gnt); else n_pass++;
`else
    cyc = 0; err = 0; vld = 0;
`endif
  endtask

  task automatic test_fill_fetch();
    logic [127:0] pat;
    logic [127:0] expd;
    pat  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    expd = INIT_EN ? '0 : init_word(9'h1A5);
    expd[127:120] = pat[127:120];
    expd[7:0]     = pat[7:0];
    @(negedge cclk);
    fill_req = 1'b1; fill_addr = 9'h1A5; fill_be = 16'h8001; fill_data = pat;
    #1;
    n_checks++; if (fill_gnt !== 1'b1 || fetch_gnt !== 1'b0) $display("[TB] FAIL ff_fill_gnt got %b%b want 10", fill_gnt, fetch_gnt); else n_pass++;
    @(negedge cclk);
    fill_req = 1'b0; fetch_req = 1'b1; fetch_addr = 9'h1A5;
    #1;
    n_checks++; if (sram_cen !== 1'b0 || sram_wen !== 16'h7FFE) $display("[TB] FAIL ff_write_cmd got cen %b wen %h want 0 7ffe", sram_cen, sram_wen); else n_pass++;
    n_checks++; if (sram_addr !== 9'h1A5 || sram_din !== pat) $display("[TB] FAIL ff_write_addr got %h %h want 1a5 %h", sram_addr, sram_din, pat); else n_pass++;
    n_checks++; if (fetch_gnt !== 1'b1) $display("[TB] FAIL ff_fetch_gnt got %b want 1", fetch_gnt); else n_pass++;
    @(negedge cclk);
    fetch_req = 1'b0;
    #1;
    n_checks++; if (sram_cen !== 1'b0 || sram_wen !== 16'hFFFF || sram_addr !== 9'h1A5) $display("[TB] FAIL ff_read_cmd got cen %b wen %h addr %h want 0 ffff 1a5", sram_cen, sram_wen, sram_addr); else n_pass++;
    n_checks++; if (fetch_rd_vld !== 1'b0) $display("[TB] FAIL ff_vld_early got %b want 0", fetch_rd_vld); else n_pass++;
    @(negedge cclk); #1;
    n_checks++; if (fetch_rd_vld !== 1'b1) $display("[TB] FAIL ff_vld got %b want 1", fetch_rd_vld); else n_pass++;
    n_checks++; if (fetch_rd_data !== expd) $display("[TB] FAIL ff_data got %h want %h", fetch_rd_data, expd); else n_pass++;
    @(negedge cclk); #1;
    n_checks++; if (fetch_rd_vld !== 1'b0) $display("[TB] FAIL ff_vld_pulse got %b want 0", fetch_rd_vld); else n_pass++;
  endtask

  task automatic test_starvation();
    logic exp_fetch;
    @(negedge cclk);
    fill_req = 1'b1; fill_addr = 9'h0F0; fill_be = 16'hFFFF; fill_data = {4{32'hDEAD_BEEF}};
    fetch_req = 1'b1; fetch_addr = 9'h010;
    for (int i = 0; i < 10; i++) begin
      exp_fetch = ((i % 5) == 4);
      #1;
      n_checks++; if (fetch_gnt !== exp_fetch) $display("[TB] FAIL starve_fetch_%0d got %b want %b", i, fetch_gnt, exp_fetch); else n_pass++;
      n_checks++; if (fill_gnt !== !exp_fetch) $display("[TB] FAIL starve_fill_%0d got %b want %b", i, fill_gnt, !exp_fetch); else n_pass++;
      @(negedge cclk);
    end
    fill_req = 1'b0; fetch_req = 1'b0;
    repeat (3) @(negedge cclk);
  endtask

  task automatic test_back_to_back();
    logic exp_vld;
    for (int k = 0; k < 4; k++) begin
      @(negedge cclk);
      fill_req = 1'b1; fill_addr = 9'(k); fill_be = 16'hFFFF; fill_data = bb_word(k);
      #1;
      n_checks++; if (fill_gnt !== 1'b1) $display("[TB] FAIL b2b_fill_gnt_%0d got %b want 1", k, fill_gnt); else n_pass++;
    end
    @(negedge cclk);
    fill_req = 1'b0;
    @(negedge cclk);
    for (int i = 0; i < 8; i++) begin
      fetch_req  = (i < 4);
      fetch_addr = 9'(i);
      #1;
      if (i < 4) begin
        n_checks++; if (fetch_gnt !== 1'b1) $display("[TB] FAIL b2b_fetch_gnt_%0d got %b want 1", i, fetch_gnt); else n_pass++;
      end
      exp_vld = (i >= 2 && i <= 5);
      n_checks++; if (fetch_rd_vld !== exp_vld) $display("[TB] FAIL b2b_vld_%0d got %b want %b", i, fetch_rd_vld, exp_vld); else n_pass++;
      if (exp_vld) begin
        n_checks++; if (fetch_rd_data !== bb_word(i - 2)) $display("[TB] FAIL b2b_data_%0d got %h want %h", i, fetch_rd_data, bb_word(i - 2)); else n_pass++;
      end
      @(negedge cclk);
    end
    fetch_req = 1'b0;
    #1;
    n_checks++; if (sram_cen !== 1'b1 || sram_wen !== 16'hFFFF) $display("[TB] FAIL idle_cmd got cen %b wen %h want 1 ffff", sram_cen, sram_wen); else n_pass++;
    n_checks++; if (sram_addr !== 9'h003 || sram_din !== bb_word(3)) $display("[TB] FAIL idle_hold got %h %h want 003 %h", sram_addr, sram_din, bb_word(3)); else n_pass++;
  endtask

  task automatic test_fill_be_zero();
    @(negedge cclk);
    fill_req = 1'b1; fill_addr = 9'h055; fill_be = 16'h0000; fill_data = '1;
    #1;
    n_checks++; if (fill_gnt !== 1'b1) $display("[TB] FAIL be0_gnt got %b want 1", fill_gnt); else n_pass++;
    @(negedge cclk);
    fill_req = 1'b0;
    #1;
    n_checks++; if (sram_cen !== 1'b1) $display("[TB] FAIL be0_cen got %b want 1", sram_cen); else n_pass++;
  endtask

  task automatic test_inv_all();
    int cyc, err, vld;
    @(negedge cclk);
    fetch_req = 1'b1; fetch_addr = 9'h001;
    #1;
    n_checks++; if (fetch_gnt !== 1'b1) $display("[TB] FAIL inv_fetch_gnt got %b want 1", fetch_gnt); else n_pass++;
    @(negedge cclk);
    fetch_req = 1'b0; inv_all_req = 1'b1;
    #1;
    n_checks++; if (init_busy !== 1'b0) $display("[TB] FAIL inv_busy_early got %b want 0", init_busy); else n_pass++;
    @(negedge cclk);
    inv_all_req = 1'b0;
    fill_req = 1'b1; fill_addr = 9'h077; fill_be = 16'hFFFF; fill_data = {4{32'h7777_0000}};
    #1;
    n_checks++; if (fetch_rd_vld !== 1'b1) $display("[TB] FAIL inv_vld got %b want 1", fetch_rd_vld); else n_pass++;
    n_checks++; if (fetch_rd_data !== bb_word(1)) $display("[TB] FAIL inv_data got %h want %h", fetch_rd_data, bb_word(1)); else n_pass++;
`ifdef P405S_ICU_SRAM_INIT_EN
    n_checks++; if (init_busy !== 1'b1) $display("[TB] FAIL inv_busy got %b want 1", init_busy); else n_pass++;
    run_sweep(cyc, err, vld);
    n_checks++; if (cyc != 512) $display("[TB] FAIL inv_sweep_len got %0d want 512", cyc); else n_pass++;
    n_checks++; if (err != 0) $display("[TB] FAIL inv_sweep_pins got %0d errors want 0", err); else n_pass++;
`else
    cyc = 0; err = 0; vld = 0;
    n_checks++; if (init_busy !== 1'b0) $display("[TB] FAIL inv_ignored got %b want 0", init_busy); else n_pass++;
`endif
    n_checks++; if (fill_gnt !== 1'b1) $display("[TB] FAIL inv_fill_after got %b want 1", fill_gnt); else n_pass++;
    @(negedge cclk);
    fill_req = 1'b0;
  endtask

  task automatic test_reset_inflight();
    int cyc, err, vld;
    @(negedge cclk);
    fetch_req = 1'b1; fetch_addr = 9'h002;
    #1;
    n_checks++; if (fetch_gnt !== 1'b1) $display("[TB] FAIL rst_fetch_gnt got %b want 1", fetch_gnt); else n_pass++;
    @(negedge cclk);
    fetch_req = 1'b0; rst_n = 1'b0;
    #1;
    n_checks++; if (sram_cen !== 1'b1 || sram_wen !== 16'hFFFF) $display("[TB] FAIL rst_cmd got cen %b wen %h want 1 ffff", sram_cen, sram_wen); else n_pass++;
    n_checks++; if (sram_addr !== 9'h000 || sram_din !== '0) $display("[TB] FAIL rst_addr got %h %h want 000 0", sram_addr, sram_din); else n_pass++;
    n_checks++; if (fetch_rd_vld !== 1'b0) $display("[TB] FAIL rst_vld got %b want 0", fetch_rd_vld); else n_pass++;
    n_checks++; if (init_busy !== INIT_EN) $display("[TB] FAIL rst_init_busy got %b want %b", init_busy, INIT_EN); else n_pass++;
    @(negedge cclk);
    rst_n = 1'b1;
    #1;
`ifdef P405S_ICU_SRAM_INIT_EN
    run_sweep(cyc, err, vld);
    n_checks++; if (cyc != 512) $display("[TB] FAIL rst_sweep_len got %0d want 512", cyc); else n_pass++;
`else
    cyc = 0; err = 0; vld = 0;
    for (int i = 0; i < 4; i++) begin
      if (fetch_rd_vld === 1'b1) vld++;
      @(negedge cclk); #1;
    end
`endif
    n_checks++; if (vld != 0) $display("[TB] FAIL rst_no_vld got %0d pulses want 0", vld); else n_pass++;
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_fill_fetch();
    test_starvation();
    test_back_to_back();
    test_fill_be_zero();
    test_inv_all();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
